// File: rtl/mp_add_ctrl_pkg.sv
// Shared defaults and FSM encoding for the slice-serial multi-precision adder.
package mp_add_ctrl_pkg;

  localparam int unsigned SLICE_W_DEF = 16;
  localparam int unsigned NSLICE_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mp_add_ctrl_pkg

// File: rtl/mp_add_ctrl_clab.sv
// W-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module clab #(
  parameter int unsigned W = 16
) (
  output logic [W-1:0] z,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);

  localparam int unsigned NG = W / 4;

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;
  logic         cc;

  // Per-group lookahead carries; cc carries the group carry into the next group.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c  = '0;
    cc = cin;
    for (int j = 0; j < int'(NG); j++) begin
      c[4*j]   = cc;
      c[4*j+1] = g[4*j] | (p[4*j] & cc);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cc);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & cc);
      cc       = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & cc);
    end
    c[W] = cc;
  end

  assign z    = p ^ c[W-1:0];
  assign cout = c[W];

endmodule : clab

// File: rtl/mp_add_ctrl.sv
// Multi-precision add/subtract: one shared CLA slice, one slice per RUN cycle.
module mp_add_ctrl
  import mp_add_ctrl_pkg::*;
#(
  parameter int unsigned SLICE_W = SLICE_W_DEF,
  parameter int unsigned NSLICE  = NSLICE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       sub,
  input  logic [SLICE_W*NSLICE-1:0]  a,
  input  logic [SLICE_W*NSLICE-1:0]  b,
  input  logic                       cin,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NSLICE-1:0]  sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int unsigned OPW  = SLICE_W * NSLICE;
  localparam int unsigned IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              step_en;
  logic              last;
  logic [OPW-1:0]    a_q;
  logic [OPW-1:0]    b_q;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] add_z;
  logic              add_co;

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step_en    = 1'b0;
    last       = (idx == IDXW'(NSLICE - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; status flags registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Current slice of the latched operands feeds the shared adder.
  always_comb begin
    a_slice = a_q[idx*SLICE_W +: SLICE_W];
    b_slice = b_q[idx*SLICE_W +: SLICE_W];
  end

  clab #(.W(SLICE_W)) u_clab (
    .z    (add_z),
    .cout (add_co),
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry)
  );

  // Operand capture on acceptance, then one slice written back per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub | cin;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (step_en) begin
      sum[idx*SLICE_W +: SLICE_W] <= add_z;
      carry <= add_co;
      if (last) begin
        idx  <= '0;
        cout <= add_co;
        ovf  <= (a_q[OPW-1] == b_q[OPW-1]) && (add_z[SLICE_W-1] != a_q[OPW-1]);
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule : mp_add_ctrl

// File: tb/tb_mp_add_ctrl.sv
// Directed + random bench for mp_add_ctrl with a result scoreboard.
module tb_mp_add_ctrl;
  import mp_add_ctrl_pkg::*;

  localparam int unsigned OPW = SLICE_W_DEF * NSLICE_DEF;
  localparam int          LAT = int'(NSLICE_DEF);

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           sub;
  logic           cin;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [OPW-1:0] sum;
  logic           cout;
  logic           ovf;

  typedef struct packed {
    logic [OPW-1:0] sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_mis    = 0;
  int   done_cnt = 0;

  mp_add_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Count done pulses seen at each rising edge.
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic on the operands as the user sees them.
  function automatic exp_t model(input logic [OPW-1:0] av, input logic [OPW-1:0] bv,
                                 input logic ci, input logic sb_mode);
    exp_t           r;
    logic [OPW-1:0] bb;
    logic [OPW:0]   full;
    bb     = sb_mode ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, bb} + (OPW+1)'(sb_mode ? 1'b1 : ci);
    r.sum  = full[OPW-1:0];
    r.cout = full[OPW];
    r.ovf  = (av[OPW-1] == bb[OPW-1]) && (r.sum[OPW-1] != av[OPW-1]);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done with a cycle bound; optionally pulse start with a=b=1 mid-run.
  task automatic wait_done(input bit disturb, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (disturb && cyc == 1) begin
        start = 1'b1;
        a     = OPW'(1);
        b     = OPW'(1);
      end else if (disturb) begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
  endtask

  task automatic check_out(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      n_vec++;
      n_mis++;
      e = '0;
      $error("FAIL %s: scoreboard empty, observed sum %0h, expected an entry", tag, sum);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".sum"},  sum,          e.sum);
    chk({tag, ".cout"}, OPW'(cout),   OPW'(e.cout));
    chk({tag, ".ovf"},  OPW'(ovf),    OPW'(e.ovf));
  endtask

  task automatic run_op(input string tag, input logic [OPW-1:0] av, input logic [OPW-1:0] bv,
                        input logic ci, input logic sm, input bit disturb);
    int   cyc;
    int   d0;
    exp_t e;
    a = av; b = bv; cin = ci; sub = sm; start = 1'b1;
    sb.push_back(model(av, bv, ci, sm));
    step();
    start = 1'b0;
    chk({tag, ".busy"}, OPW'(busy), OPW'(1));
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = 1'($urandom);
    sub = 1'($urandom);
    d0  = done_cnt;
    wait_done(disturb, cyc);
    chk({tag, ".lat"}, OPW'(cyc), OPW'(LAT));
    check_out(tag, e);
    step();
    chk({tag, ".ready"}, OPW'(ready), OPW'(1));
    chk({tag, ".ndone"}, OPW'(done_cnt - d0), OPW'(1));
    step();
    chk({tag, ".hold"}, sum, e.sum);
  endtask

  initial begin
    int   cyc;
    int   d0;
    exp_t e;
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #1;
    chk("rst.ready", OPW'(ready), OPW'(1));
    chk("rst.busy",  OPW'(busy),  OPW'(0));
    chk("rst.done",  OPW'(done),  OPW'(0));
    chk("rst.sum",   sum,         OPW'(0));
    chk("rst.cout",  OPW'(cout),  OPW'(0));
    chk("rst.ovf",   OPW'(ovf),   OPW'(0));
    step(); step();
    reset = 1'b0;

    run_op("add_small", OPW'(64'hA), OPW'(64'hB), 1'b0, 1'b0, 1'b0);
    run_op("slice_cy",  OPW'(64'hFFFF), OPW'(64'h1), 1'b0, 1'b0, 1'b0);
    run_op("wrap",      OPW'(64'hFFFF_FFFF_FFFF_FFFF), OPW'(64'h1), 1'b0, 1'b0, 1'b0);
    run_op("pos_ovf",   OPW'(64'h7FFF_FFFF_FFFF_FFFF), OPW'(64'h1), 1'b0, 1'b0, 1'b0);
    run_op("sub_neg",   OPW'(64'h5), OPW'(64'h7), 1'b1, 1'b1, 1'b0);
    run_op("sub_pos",   OPW'(64'h7), OPW'(64'h5), 1'b0, 1'b1, 1'b0);
    run_op("add_cin",   OPW'(64'h0123_4567_89AB_CDEF), OPW'(64'hFEDC_BA98_7654_3210), 1'b1, 1'b0, 1'b0);
    run_op("start_run", OPW'(64'h8000_0000_0000_0000), OPW'(64'h8000_0000_0000_0001), 1'b0, 1'b0, 1'b1);

    // Reset in the second RUN cycle aborts with no done pulse.
    a = OPW'(64'h1111_2222_3333_4444); b = OPW'(64'h5555); cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("abort.ready", OPW'(ready), OPW'(1));
    chk("abort.busy",  OPW'(busy),  OPW'(0));
    chk("abort.sum",   sum,         OPW'(0));
    step(); step(); step();
    reset = 1'b0;
    chk("abort.ndone", OPW'(done_cnt - d0), OPW'(0));
    run_op("post_rst", OPW'(64'hDEAD_BEEF_0000_FFFF), OPW'(64'h0000_0001_0000_0001), 1'b0, 1'b0, 1'b0);

    // Start held high: second operation accepted on the first IDLE cycle after DONE.
    a = OPW'(64'h0000_0000_FFFF_FFFF); b = OPW'(64'h1); cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    step();
    a = OPW'(64'h10); b = OPW'(64'h30); cin = 1'b0; sub = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    wait_done(1'b0, cyc);
    chk("b2b1.lat", OPW'(cyc), OPW'(LAT));
    check_out("b2b1", e);
    step();
    chk("b2b.ready", OPW'(ready), OPW'(1));
    step();
    start = 1'b0;
    chk("b2b.busy", OPW'(busy), OPW'(1));
    wait_done(1'b0, cyc);
    chk("b2b2.lat", OPW'(cyc), OPW'(LAT));
    check_out("b2b2", e);
    step();

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("rnd%0d", i), {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), 1'($urandom), 1'b0);
    end

    chk("sb.empty", OPW'(sb.size()), OPW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_mp_add_ctrl
